// File: rtl/data_mem_responder_if.sv
// Processor-to-data-memory bus: request signals from the processor, load data and status back.
// The processor side uses the master modport and the memory side uses the slave modport.
interface data_mem_responder_if #(
    parameter int ADDR_W   = 16,
    parameter int WB_DEPTH = 4
);
    logic [ADDR_W-1:0]          Address;
    logic                       ReadEn;
    logic                       WriteEn;
    logic [31:0]                WriteData;
    logic [31:0]                ReadData;
    logic [$clog2(WB_DEPTH):0]  PendingCount;
    logic                       Misaligned;

    modport master (
        output Address, ReadEn, WriteEn, WriteData,
        input  ReadData, PendingCount, Misaligned
    );

    modport slave (
        input  Address, ReadEn, WriteEn, WriteData,
        output ReadData, PendingCount, Misaligned
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word array behind a posted-write FIFO.
// Loads see the youngest buffered store to the same word; otherwise they read the array.
module data_mem_responder #(
    parameter int ADDR_W    = 16,
    parameter int MEM_WORDS = 256,
    parameter int WB_DEPTH  = 4
) (
    input  logic                 Clock,
    input  logic                 nReset,
    data_mem_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      r_mem    [MEM_WORDS];
    logic [IDX_W-1:0] r_wbIdx  [WB_DEPTH];
    logic [31:0]      r_wbData [WB_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_misaligned;

    logic [IDX_W-1:0] w_index;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_fwdHit;
    logic [31:0]      w_fwdData;
    logic [PTR_W-1:0] w_slot;

    assign w_index = IDX_W'(32'(bus.Address[ADDR_W-1:2]) % MEM_WORDS);
    assign w_full  = (r_count == CNT_W'(WB_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.WriteEn;
    // Loads get the array port, except a full buffer must drain so a new store always fits.
    assign w_pop   = !w_empty && (!bus.ReadEn || w_full);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_wbIdx[r_tail]  <= w_index;
            r_wbData[r_tail] <= bus.WriteData;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
        end else if (w_pop) begin
            r_mem[r_wbIdx[r_head]] <= r_wbData[r_head];
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            r_misaligned <= 1'b0;
        else if ((bus.ReadEn || bus.WriteEn) && (bus.Address[1:0] != 2'b00))
            r_misaligned <= 1'b1;
    end

    // Walk oldest to youngest so the last matching entry wins.
    always_comb begin
        w_fwdHit  = 1'b0;
        w_fwdData = '0;
        w_slot    = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            w_slot = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_wbIdx[w_slot] == w_index)) begin
                w_fwdHit  = 1'b1;
                w_fwdData = r_wbData[w_slot];
            end
        end
    end

    assign bus.ReadData     = bus.ReadEn ? (w_fwdHit ? w_fwdData : r_mem[w_index]) : 32'h0;
    assign bus.PendingCount = r_count;
    assign bus.Misaligned   = r_misaligned;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: stimulus pushes expected outputs into a queue,
// a monitor pops one entry per cycle and compares ReadData, PendingCount and Misaligned.
module tb_data_mem_responder;
    typedef struct {
        string       name;
        logic [31:0] data;
        logic [2:0]  cnt;
        logic        mis;
    } expT;

    logic clock;
    logic nReset;
    expT  expQ[$];
    int   checks;
    int   errors;
    logic misExp;

    data_mem_responder_if #(.ADDR_W(16), .WB_DEPTH(4)) bus();

    data_mem_responder #(.ADDR_W(16), .MEM_WORDS(256), .WB_DEPTH(4)) dut (
        .Clock  (clock),
        .nReset (nReset),
        .bus    (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge and queue what the outputs must show this cycle.
    task automatic applyStimulus(input string name, input logic [15:0] addr, input logic rd,
                                 input logic wr, input logic [31:0] wd,
                                 input logic [31:0] expData, input logic [2:0] expCnt);
        expT e;
        @(posedge clock);
        #1;
        bus.Address   = addr;
        bus.ReadEn    = rd;
        bus.WriteEn   = wr;
        bus.WriteData = wd;
        e.name = name;
        e.data = expData;
        e.cnt  = expCnt;
        e.mis  = misExp;
        expQ.push_back(e);
    endtask

    initial begin
        expT e;
        forever begin
            @(negedge clock);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput({e.name, "_data"}, bus.ReadData, e.data);
                checkOutput({e.name, "_cnt"}, 32'(bus.PendingCount), 32'(e.cnt));
                checkOutput({e.name, "_mis"}, 32'(bus.Misaligned), 32'(e.mis));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int waitCycles;
        checks        = 0;
        errors        = 0;
        misExp        = 1'b0;
        nReset        = 1'b0;
        bus.Address   = '0;
        bus.ReadEn    = 1'b0;
        bus.WriteEn   = 1'b0;
        bus.WriteData = '0;
        repeat (3) @(posedge clock);
        #1 nReset = 1'b1;

        $display("[TB] reset and forwarding");
        applyStimulus("t1_reset", 16'h0040, 1, 0, 0, 32'h0, 0);
        applyStimulus("t2_store", 16'h0010, 0, 1, 32'hDEADBEEF, 32'h0, 0);
        applyStimulus("t2_fwd0",  16'h0010, 1, 0, 0, 32'hDEADBEEF, 1);
        applyStimulus("t2_fwd1",  16'h0010, 1, 0, 0, 32'hDEADBEEF, 1);
        applyStimulus("t2_idle0", 16'h0000, 0, 0, 0, 32'h0, 1);
        applyStimulus("t2_idle1", 16'h0000, 0, 0, 0, 32'h0, 0);
        applyStimulus("t2_array", 16'h0010, 1, 0, 0, 32'hDEADBEEF, 0);

        $display("[TB] full buffer");
        applyStimulus("t3_w0", 16'h0000, 1, 1, 32'd1, 32'h0, 0);
        applyStimulus("t3_w1", 16'h0004, 1, 1, 32'd2, 32'h0, 1);
        applyStimulus("t3_w2", 16'h0008, 1, 1, 32'd3, 32'h0, 2);
        applyStimulus("t3_w3", 16'h000C, 1, 1, 32'd4, 32'h0, 3);
        applyStimulus("t3_w4", 16'h0010, 1, 1, 32'd5, 32'hDEADBEEF, 4);
        applyStimulus("t3_r0", 16'h0000, 1, 0, 0, 32'd1, 4);
        applyStimulus("t3_r1", 16'h0004, 1, 0, 0, 32'd2, 3);
        applyStimulus("t3_r2", 16'h0008, 1, 0, 0, 32'd3, 3);
        applyStimulus("t3_r3", 16'h000C, 1, 0, 0, 32'd4, 3);
        applyStimulus("t3_r4", 16'h0010, 1, 0, 0, 32'd5, 3);
        applyStimulus("t3_d0", 16'h0000, 0, 0, 0, 32'h0, 3);
        applyStimulus("t3_d1", 16'h0000, 0, 0, 0, 32'h0, 2);
        applyStimulus("t3_d2", 16'h0000, 0, 0, 0, 32'h0, 1);
        applyStimulus("t3_d3", 16'h0000, 0, 0, 0, 32'h0, 0);
        applyStimulus("t3_a0", 16'h0000, 1, 0, 0, 32'd1, 0);
        applyStimulus("t3_a4", 16'h0010, 1, 0, 0, 32'd5, 0);

        $display("[TB] same-cycle read after write");
        applyStimulus("t4_old", 16'h0020, 0, 1, 32'd7, 32'h0, 0);
        applyStimulus("t4_i0",  16'h0000, 0, 0, 0, 32'h0, 1);
        applyStimulus("t4_i1",  16'h0000, 0, 0, 0, 32'h0, 0);
        applyStimulus("t4_raw", 16'h0020, 1, 1, 32'd9, 32'd7, 0);
        applyStimulus("t4_new", 16'h0020, 1, 0, 0, 32'd9, 1);
        applyStimulus("t4_i2",  16'h0000, 0, 0, 0, 32'h0, 1);
        applyStimulus("t4_i3",  16'h0000, 0, 0, 0, 32'h0, 0);
        applyStimulus("t4_arr", 16'h0020, 1, 0, 0, 32'd9, 0);

        $display("[TB] same-index ordering");
        applyStimulus("t5_a",  16'h0030, 0, 1, 32'hA, 32'h0, 0);
        applyStimulus("t5_b",  16'h0030, 0, 1, 32'hB, 32'h0, 1);
        applyStimulus("t5_r0", 16'h0030, 1, 0, 0, 32'hB, 1);
        applyStimulus("t5_r1", 16'h0030, 1, 0, 0, 32'hB, 1);
        applyStimulus("t5_i0", 16'h0000, 0, 0, 0, 32'h0, 1);
        applyStimulus("t5_i1", 16'h0000, 0, 0, 0, 32'h0, 0);
        applyStimulus("t5_r2", 16'h0030, 1, 0, 0, 32'hB, 0);

        $display("[TB] misaligned, wrap-around and reset mid-drain");
        applyStimulus("t6_mis", 16'h0031, 1, 0, 0, 32'hB, 0);
        misExp = 1'b1;
        applyStimulus("t6_flag", 16'h0030, 1, 0, 0, 32'hB, 0);
        applyStimulus("t6_wrap", 16'h0400, 0, 1, 32'h55, 32'h0, 0);
        applyStimulus("t6_wi",   16'h0000, 0, 0, 0, 32'h0, 1);
        applyStimulus("t6_wr",   16'h0000, 1, 0, 0, 32'h55, 0);
        applyStimulus("t6_p0", 16'h0040, 1, 1, 32'd11, 32'h0, 0);
        applyStimulus("t6_p1", 16'h0044, 1, 1, 32'd12, 32'h0, 1);
        applyStimulus("t6_p2", 16'h0048, 1, 1, 32'd13, 32'h0, 2);
        applyStimulus("t6_p3", 16'h0000, 0, 0, 0, 32'h0, 3);
        @(negedge clock);
        #1 nReset = 1'b0;
        misExp = 1'b0;
        applyStimulus("t6_rst", 16'h0040, 1, 0, 0, 32'h0, 0);
        @(posedge clock);
        #1 nReset = 1'b1;
        applyStimulus("t6_z00", 16'h0000, 1, 0, 0, 32'h0, 0);
        applyStimulus("t6_z10", 16'h0010, 1, 0, 0, 32'h0, 0);
        applyStimulus("t6_z30", 16'h0030, 1, 0, 0, 32'h0, 0);
        applyStimulus("t6_z40", 16'h0040, 1, 0, 0, 32'h0, 0);
        applyStimulus("t6_z44", 16'h0044, 1, 0, 0, 32'h0, 0);
        applyStimulus("t6_z48", 16'h0048, 1, 0, 0, 32'h0, 0);
        applyStimulus("t6_end", 16'h0000, 0, 0, 0, 32'h0, 0);

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(negedge clock);
            waitCycles++;
        end
        #1;
        if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain_queue: got %0d entries left expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
